// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    localparam int DATA_BUS_BITS = 32;
    localparam int LEN_BITS      = 16;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_LO,
        LD_LEN_HI,
        LD_DATA,
        LD_WRITE,
        LD_DONE,
        LD_ERR
    } ld_state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Byte packer: shifts little-endian bytes into a word and flags the last byte of each word.
module word_assembler #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word_next,
    output logic              o_word_complete
);
    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    logic [DATA_W-1:0] r_word;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_word_next;

    // New byte enters at the top; after BYTES loads the first byte sits in bits [7:0].
    assign w_word_next     = (r_word >> 8) | (DATA_W'(i_byte) << (DATA_W - 8));
    assign o_word_next     = w_word_next;
    assign o_word_complete = (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_word <= w_word_next;
            r_cnt  <= o_word_complete ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader that fills instruction memory from word 0
// and holds the core in reset until a complete image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_W    = DATA_BUS_BITS,
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1 << ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [DATA_W-1:0] o_imem_wdata,
    output logic              o_cpu_reset,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);
    localparam int CW = LEN_BITS + 1;
    localparam logic [CW-1:0]     MAX_LEN = CW'(MAX_WORDS);
    localparam logic [ADDR_W:0]   IDX_ONE = (ADDR_W + 1)'(1);

    ld_state_e          r_state, w_state_next;
    logic               r_rst_meta, r_rst_sync;
    logic [LEN_BITS-1:0] r_len;
    logic [ADDR_W:0]    r_index;
    logic               r_in_ready, r_imem_we, r_cpu_reset, r_busy, r_done, r_error;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic [DATA_W-1:0]  r_imem_wdata;

    logic               w_rst_n, w_hs, w_start_ok, w_len_bad, w_last_word;
    logic               w_word_complete;
    logic [LEN_BITS-1:0] w_len_full;
    logic [DATA_W-1:0]  w_word_next;

    // Assert asynchronously, release on the clock.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end
    assign w_rst_n = r_rst_sync;

    assign w_hs        = i_in_valid && r_in_ready;
    assign w_start_ok  = i_start && ((r_state == LD_IDLE) || (r_state == LD_DONE) || (r_state == LD_ERR));
    assign w_len_full  = {i_in_data, r_len[7:0]};
    assign w_len_bad   = (w_len_full == '0) || ({1'b0, w_len_full} > MAX_LEN);
    assign w_last_word = (CW'(r_index) + CW'(1)) == {1'b0, r_len};

    word_assembler #(.DATA_W(DATA_W)) u_asm (
        .i_clk          (i_clk),
        .i_rst_n        (w_rst_n),
        .i_clear        (w_start_ok),
        .i_load         (w_hs && (r_state == LD_DATA)),
        .i_byte         (i_in_data),
        .o_word_next    (w_word_next),
        .o_word_complete(w_word_complete)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LD_IDLE, LD_DONE, LD_ERR: if (w_start_ok) w_state_next = LD_LEN_LO;
            LD_LEN_LO: if (w_hs) w_state_next = LD_LEN_HI;
            LD_LEN_HI: if (w_hs) w_state_next = w_len_bad ? LD_ERR : LD_DATA;
            LD_DATA:   if (w_hs && w_word_complete) w_state_next = LD_WRITE;
            LD_WRITE:  w_state_next = w_last_word ? LD_DONE : LD_DATA;
            default:   w_state_next = LD_IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state so they line up with r_state.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= LD_IDLE;
            r_len        <= '0;
            r_index      <= '0;
            r_in_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == LD_LEN_LO) || (w_state_next == LD_LEN_HI) ||
                           (w_state_next == LD_DATA);
            r_imem_we   <= (w_state_next == LD_WRITE);
            r_busy      <= (w_state_next == LD_LEN_LO) || (w_state_next == LD_LEN_HI) ||
                           (w_state_next == LD_DATA) || (w_state_next == LD_WRITE);
            r_done      <= (w_state_next == LD_DONE);
            r_error     <= (w_state_next == LD_ERR);
            r_cpu_reset <= (w_state_next != LD_DONE);

            if (r_state == LD_LEN_LO && w_hs) r_len[7:0]  <= i_in_data;
            if (r_state == LD_LEN_HI && w_hs) r_len[15:8] <= i_in_data;

            if (w_start_ok)                r_index <= '0;
            else if (r_state == LD_WRITE)  r_index <= r_index + IDX_ONE;

            if (r_state == LD_DATA && w_hs && w_word_complete) begin
                r_imem_addr  <= r_index[ADDR_W-1:0];
                r_imem_wdata <= w_word_next;
            end
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_cpu_reset  = r_cpu_reset;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes come from an image-level model.
module tb_imem_loader;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int MAXW   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              o_in_ready, o_imem_we, o_cpu_reset, o_busy, o_done, o_error;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [DATA_W-1:0] o_imem_wdata;

    imem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_start     (start),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (o_in_ready),
        .o_imem_we   (o_imem_we),
        .o_imem_addr (o_imem_addr),
        .o_imem_wdata(o_imem_wdata),
        .o_cpu_reset (o_cpu_reset),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                c;
    } wr_t;

    wr_t         act_q[$];
    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          n_pass = 0;
    int          n_total = 0;

    // Every write is logged; the stream must be stalled while the write happens.
    always @(negedge clk) begin
        wr_t w;
        if (rst_n && o_imem_we) begin
            w.addr = o_imem_addr;
            w.data = o_imem_wdata;
            w.c    = cyc;
            act_q.push_back(w);
            n_total++;
            if (o_in_ready !== 1'b0 || o_busy !== 1'b1)
                $display("FAIL write_flags in_ready=%0b busy=%0b required in_ready=0 busy=1", o_in_ready, o_busy);
            else
                n_pass++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, output int hs_cyc);
        bit got;
        got = 1'b0;
        hs_cyc = -1;
        if (gaps) repeat ($urandom_range(0, 3)) tick();
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (o_in_ready === 1'b1) begin
                got = 1'b1;
                hs_cyc = cyc + 1;
            end
            tick();
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!got) begin
            n_total++;
            $display("FAIL handshake_timeout byte=%02h: no in_ready in 50 cycles, required a handshake", b);
        end
    endtask

    // Streams length n plus img words; the model says a legal n yields writes
    // addr i = img[i] one cycle after each word's last byte, then DONE; else ERR.
    task automatic stream_image(input int n, input bit gaps, input bit mid_start,
                                input bit do_start, input string name);
        int          hc;
        logic [15:0] nl;
        logic [31:0] w;
        bit          ok;
        wr_t         e;
        nl = 16'(n);
        ok = (n >= 1) && (n <= MAXW);
        act_q.delete();
        exp_q.delete();
        if (do_start) pulse_start();
        send_byte(nl[7:0], gaps, hc);
        send_byte(nl[15:8], gaps, hc);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                w = img[i];
                for (int k = 0; k < 4; k++) begin
                    send_byte(w[8*k +: 8], gaps, hc);
                    if (mid_start && i == 0 && k == 0) pulse_start();
                end
                e.addr = ADDR_W'(i % MAXW);
                e.data = w;
                e.c    = hc;
                exp_q.push_back(e);
            end
        end
        repeat (3) tick();
        n_total++;
        if (act_q.size() != exp_q.size())
            $display("FAIL %s write_count got=%0d required=%0d", name, act_q.size(), exp_q.size());
        else
            n_pass++;
        for (int j = 0; j < exp_q.size() && j < act_q.size(); j++) begin
            n_total++;
            if (act_q[j].addr !== exp_q[j].addr || act_q[j].data !== exp_q[j].data || act_q[j].c != exp_q[j].c)
                $display("FAIL %s write[%0d] got addr=%0d data=%08h cyc=%0d required addr=%0d data=%08h cyc=%0d",
                         name, j, act_q[j].addr, act_q[j].data, act_q[j].c,
                         exp_q[j].addr, exp_q[j].data, exp_q[j].c);
            else
                n_pass++;
        end
        n_total++;
        if ({o_done, o_error, o_cpu_reset, o_busy, o_in_ready} !== {ok, !ok, !ok, 1'b0, 1'b0})
            $display("FAIL %s final_status got done/err/cpu_rst/busy/rdy=%b required %b", name,
                     {o_done, o_error, o_cpu_reset, o_busy, o_in_ready}, {ok, !ok, !ok, 1'b0, 1'b0});
        else
            n_pass++;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) tick();
        n_total++;
        if ({o_in_ready, o_imem_we, o_busy, o_done, o_error, o_cpu_reset} !== 6'b000001 ||
            o_imem_addr !== '0 || o_imem_wdata !== '0)
            $display("FAIL reset_values got rdy/we/busy/done/err/cpu_rst=%b addr=%0d data=%08h required 000001 0 0",
                     {o_in_ready, o_imem_we, o_busy, o_done, o_error, o_cpu_reset}, o_imem_addr, o_imem_wdata);
        else
            n_pass++;
        rst_n = 1'b1;
        repeat (4) tick();
        n_total++;
        if ({o_in_ready, o_busy, o_done, o_error, o_cpu_reset} !== 5'b00001)
            $display("FAIL idle_after_reset got rdy/busy/done/err/cpu_rst=%b required 00001",
                     {o_in_ready, o_busy, o_done, o_error, o_cpu_reset});
        else
            n_pass++;
    endtask

    task automatic test_normal();
        img.delete();
        img.push_back(32'h0000_0013);
        img.push_back(32'h0010_0093);
        stream_image(2, 1'b0, 1'b0, 1'b1, "normal");
        n_total++;
        if (act_q.size() < 2 || act_q[1].data !== 32'h0010_0093 || act_q[1].addr !== 4'd1)
            $display("FAIL normal_word1 got %0d writes, required addr1=00100093", act_q.size());
        else
            n_pass++;
    endtask

    task automatic test_zero_len();
        stream_image(0, 1'b0, 1'b0, 1'b1, "zero_len");
        pulse_start();
        n_total++;
        if (o_error !== 1'b0 || o_busy !== 1'b1 || o_cpu_reset !== 1'b1)
            $display("FAIL err_restart got err=%0b busy=%0b cpu_rst=%0b required 0 1 1", o_error, o_busy, o_cpu_reset);
        else
            n_pass++;
        fill_img(1);
        stream_image(1, 1'b0, 1'b0, 1'b0, "zero_recover");
    endtask

    task automatic test_oversize();
        stream_image(17, 1'b0, 1'b0, 1'b1, "over17");
        stream_image(256, 1'b0, 1'b0, 1'b1, "over256");
        fill_img(16);
        stream_image(16, 1'b0, 1'b0, 1'b1, "max16");
        n_total++;
        if (act_q.size() < 16 || act_q[15].addr !== 4'd15)
            $display("FAIL max16_last_addr got %0d writes, required last addr 15", act_q.size());
        else
            n_pass++;
    endtask

    task automatic test_gaps();
        int n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            fill_img(n);
            stream_image(n, 1'b1, 1'b0, 1'b1, "gaps");
        end
    endtask

    task automatic test_reset_mid();
        int hc;
        fill_img(2);
        pulse_start();
        send_byte(8'h02, 1'b0, hc);
        send_byte(8'h00, 1'b0, hc);
        send_byte(8'hAA, 1'b0, hc);
        send_byte(8'hBB, 1'b0, hc);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({o_imem_we, o_cpu_reset, o_busy, o_in_ready} !== 4'b0100)
            $display("FAIL reset_mid_word got we/cpu_rst/busy/rdy=%b required 0100",
                     {o_imem_we, o_cpu_reset, o_busy, o_in_ready});
        else
            n_pass++;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        pulse_start();
        send_byte(8'h01, 1'b0, hc);
        send_byte(8'h00, 1'b0, hc);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1'b0, hc);
        n_total++;
        if (o_imem_we !== 1'b1)
            $display("FAIL write_pulse_before_reset got we=%0b required 1", o_imem_we);
        else
            n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (o_imem_we !== 1'b0 || o_cpu_reset !== 1'b1)
            $display("FAIL reset_in_write got we=%0b cpu_rst=%0b required 0 1", o_imem_we, o_cpu_reset);
        else
            n_pass++;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        stream_image(2, 1'b1, 1'b0, 1'b1, "after_reset");
    endtask

    task automatic test_start_ignored();
        fill_img(3);
        stream_image(3, 1'b1, 1'b1, 1'b1, "start_in_data");
    endtask

    task automatic test_start_done();
        n_total++;
        if (o_done !== 1'b1 || o_cpu_reset !== 1'b0)
            $display("FAIL done_state got done=%0b cpu_rst=%0b required 1 0", o_done, o_cpu_reset);
        else
            n_pass++;
        pulse_start();
        n_total++;
        if (o_cpu_reset !== 1'b1 || o_done !== 1'b0 || o_in_ready !== 1'b1)
            $display("FAIL restart_from_done got cpu_rst=%0b done=%0b rdy=%0b required 1 0 1",
                     o_cpu_reset, o_done, o_in_ready);
        else
            n_pass++;
        fill_img(2);
        stream_image(2, 1'b0, 1'b0, 1'b0, "reload");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero_len();
        test_oversize();
        test_gaps();
        test_reset_mid();
        test_start_ignored();
        test_start_done();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish within 500000 time units");
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream program loader that writes the instruction memory through its write port (imme_we / address / data). This is the writer side of the instruction memory that the control unit decodes from.
- Accepts a length-prefixed little-endian byte stream on a valid/ready handshake.
- Assembles 32-bit instruction words and writes them to consecutive word addresses from 0.
- Holds the core in reset until a complete, valid image is loaded.

Parameters:
DATA_W, `DataBusBits (32), instruction word width; must be a multiple of 8.
ADDR_W, 10, instruction memory word-address width.
MAX_WORDS, 1<<ADDR_W, largest accepted image length in words.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR.
in_valid  in  1  byte-stream valid.
in_data  in  8  byte-stream data.
in_ready  out  1  byte accepted when in_valid && in_ready at a rising clk edge.
imem_we  out  1  instruction memory write enable, one-cycle pulse.
imem_addr  out  ADDR_W  word address of the current write.
imem_wdata  out  DATA_W  instruction word being written.
cpu_reset  out  1  active-high reset to the core's pc_reset/reg_rst.
busy  out  1  high in LEN_LO, LEN_HI, DATA and WRITE.
done  out  1  high in DONE.
error  out  1  high in ERR.

Behaviour:
- All outputs registered. Reset (async assert, sync deassert internally):
  - state=IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0.
  - cpu_reset=1, so the core stays held until a successful load.
- Stream format:
  - len[7:0], then len[15:8] (16-bit word count N).
  - Then N*(DATA_W/8) bytes, least-significant byte first per word.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- IDLE: in_ready=0. start -> LEN_LO; clear word index and byte counter.
- LEN_LO: in_ready=1. On handshake, latch the low byte -> LEN_HI.
- LEN_HI: in_ready=1. On handshake, latch the high byte and check N:
  - N==0 or N>MAX_WORDS -> ERR.
  - Otherwise -> DATA.
- DATA: in_ready=1. On each handshake, byte k goes into bits [8k+7:8k]; byte counter increments.
  - On the last byte of a word -> WRITE; the byte counter wraps to 0.
- WRITE: in_ready=0; imem_we=1 for exactly one cycle with imem_addr=index and the assembled word. Then index increments:
  - index+1==N -> DONE.
  - Otherwise -> DATA.
- Latency: imem_we is high in the cycle immediately after the handshake of the word's final byte.
- Throughput: at most one word per (DATA_W/8)+1 cycles.
- in_valid gaps of any length are tolerated; no state advances without a handshake.
- DONE: cpu_reset=0, done=1, in_ready=0. Extra stream bytes are not accepted. start -> LEN_LO, re-asserting cpu_reset=1 on the next cycle.
- ERR: cpu_reset=1, error=1, in_ready=0. start -> LEN_LO and clears error.
- start in LEN_LO, LEN_HI, DATA or WRITE is ignored.
- cpu_reset is 1 in every state except DONE.
- Width rules:
  - Internal index is ADDR_W+1 bits, so N==MAX_WORDS completes without wrap.
  - imem_addr takes the low ADDR_W bits of the index.
  - N is compared as unsigned 16-bit against MAX_WORDS.
- reset_n low mid-operation: imem_we drops immediately (async), partial word discarded, state=IDLE, cpu_reset=1. Memory contents already written are untouched.

Decomposition:
- Shared header DIAGV.vh holds DataBusBits plus new macros: LoaderStateBits and the state encodings LD_IDLE..LD_ERR, LenBits=16.
- One sub-module, word_assembler: shift/insert byte packer with byte counter and word_complete flag. It is cleared by the FSM at start and on reset.
- The FSM, index and length registers live in imem_loader.

Test Plan:
- Normal load: reset, start, stream 02 00 13 00 00 00 93 00 10 00 -> writes addr0=0x00000013 and addr1=0x00100093, one cycle after each 4th byte. Then done=1 and cpu_reset=0.
- Zero length: stream 00 00 -> ERR, error=1, cpu_reset=1, no imem_we. A following start plus a valid 1-word image -> DONE.
- Oversize (ADDR_W=4): N=17 -> ERR. N=16 -> 16 writes to addr 0..15, then DONE with no address wrap.
- Backpressure/gaps: randomly deassert in_valid between bytes -> identical writes and timing relative to handshakes. in_ready=0 during every WRITE cycle.
- Reset mid-word: assert reset_n low after 2 data bytes -> imem_we=0 and cpu_reset=1 immediately. A fresh start plus image loads correctly from addr 0.
- start during DATA ignored; start in DONE -> cpu_reset returns to 1 and a second image overwrites from addr 0.
